// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states,
// opcodes, ALU/immediate/mux select codes and the internal control bundle.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_EXEC_R, S_EXEC_I, S_EXEC_U, S_ALU_WB, S_BRANCH, S_JAL,
    S_JALR_ADR, S_JALR, S_ILLEGAL
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_RESULT = 1'b1;

  // How the ALU decoder interprets funct3/funct7b5.
  typedef enum logic [1:0] {ALUM_ADD, ALUM_R, ALUM_I} alu_mode_t;

  // Everything the FSM drives except imm_src and the decoded ALU code.
  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    alu_mode_t  alu_mode;
    logic       reg_write;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

  // Immediate format depends only on the opcode.
  function automatic logic [2:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_IMM, OP_JALR: imm_sel = IMM_I;
      OP_STORE:                 imm_sel = IMM_S;
      OP_BRANCH:                imm_sel = IMM_B;
      OP_JAL:                   imm_sel = IMM_J;
      OP_LUI, OP_AUIPC:         imm_sel = IMM_U;
      default:                  imm_sel = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// funct3/funct7b5 to ALU operation; I-mode never subtracts on funct3=000.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_mode_t  mode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] alu_control
);

  // Decode operation from mode and function fields.
  always_comb begin
    alu_control = ALU_ADD;
    if (mode != ALUM_ADD) begin
      case (funct3)
        3'b000: alu_control = (mode == ALUM_R && funct7b5) ? ALU_SUB : ALU_ADD;
        3'b001: alu_control = ALU_SLL;
        3'b010: alu_control = ALU_SLT;
        3'b011: alu_control = ALU_SLTU;
        3'b100: alu_control = ALU_XOR;
        3'b101: alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
        3'b110: alu_control = ALU_OR;
        default: alu_control = ALU_AND;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RV32I core. Only BRANCH's pc_write
// looks at the ALU flags; reset masks every enable combinationally so an
// interrupted instruction makes no writes in the reset cycle.
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_control,
  output logic [2:0] imm_src,
  output logic       reg_write,
  output logic       instr_done,
  output logic       illegal
);

  state_t state, next_state;
  ctrl_t  c;
  logic   taken, br_ok;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  // Branch condition; funct3 010/011 are not valid branches.
  always_comb begin
    taken = 1'b0;
    br_ok = 1'b1;
    case (funct3)
      3'b000: taken = zero;
      3'b001: taken = ~zero;
      3'b100: taken = lt;
      3'b101: taken = ~lt;
      3'b110: taken = ltu;
      3'b111: taken = ~ltu;
      default: br_ok = 1'b0;
    endcase
  end

  // Next state and per-state control.
  always_comb begin
    next_state = state;
    c          = '0;
    c.alu_mode = ALUM_ADD;
    case (state)
      S_FETCH: begin
        c.adr_src = ADR_PC;     c.ir_write = 1'b1;   c.pc_write = 1'b1;
        c.alu_src_a = SRCA_PC;  c.alu_src_b = SRCB_FOUR;
        c.result_src = RES_ALU;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        // Branch/JAL target goes into alu_out while decoding.
        c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: next_state = S_MEM_ADR;
          OP_R:              next_state = S_EXEC_R;
          OP_IMM:            next_state = S_EXEC_I;
          OP_BRANCH:         next_state = S_BRANCH;
          OP_JAL:            next_state = S_JAL;
          OP_JALR:           next_state = S_JALR_ADR;
          OP_LUI, OP_AUIPC:  next_state = S_EXEC_U;
          default:           next_state = S_ILLEGAL;
        endcase
      end
      S_MEM_ADR: begin
        c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_IMM;
        next_state = (op == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        c.adr_src = ADR_RESULT; c.result_src = RES_ALUOUT;
        next_state = S_MEM_WB;
      end
      S_MEM_WB: begin
        c.result_src = RES_MEM; c.reg_write = 1'b1; c.instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_MEM_WRITE: begin
        c.adr_src = ADR_RESULT; c.result_src = RES_ALUOUT;
        c.mem_write = 1'b1;     c.instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_EXEC_R: begin
        c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_RS2; c.alu_mode = ALUM_R;
        next_state = S_ALU_WB;
      end
      S_EXEC_I: begin
        c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_IMM; c.alu_mode = ALUM_I;
        next_state = S_ALU_WB;
      end
      S_EXEC_U: begin
        // LUI adds imm to zero, AUIPC to the instruction's own PC.
        c.alu_src_a = (op == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
        next_state = S_ALU_WB;
      end
      S_ALU_WB: begin
        c.result_src = RES_ALUOUT; c.reg_write = 1'b1; c.instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_RS2; c.alu_mode = ALUM_ADD;
        c.result_src = RES_ALUOUT; c.instr_done = 1'b1;
        c.pc_write = br_ok & taken;
        next_state = br_ok ? S_FETCH : S_ILLEGAL;
      end
      S_JAL: begin
        c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_FOUR;
        c.result_src = RES_ALUOUT; c.pc_write = 1'b1;
        next_state = S_ALU_WB;
      end
      S_JALR_ADR: begin
        c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_IMM;
        next_state = S_JALR;
      end
      S_JALR: begin
        c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_FOUR;
        c.result_src = RES_ALUOUT; c.pc_write = 1'b1;
        next_state = S_ALU_WB;
      end
      S_ILLEGAL: begin
        c.illegal = 1'b1;
        next_state = S_ILLEGAL;
      end
      default: next_state = S_FETCH;
    endcase
    if (reset) begin
      next_state   = S_FETCH;
      c.pc_write   = 1'b0;
      c.mem_write  = 1'b0;
      c.ir_write   = 1'b0;
      c.reg_write  = 1'b0;
      c.instr_done = 1'b0;
      c.illegal    = 1'b0;
    end
  end

  logic [3:0] dec_alu;

  alu_decoder u_alu_dec (
    .mode        (c.alu_mode),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_control (dec_alu)
  );

  // BRANCH compares with SUB regardless of funct3.
  assign alu_control = (state == S_BRANCH) ? ALU_SUB : dec_alu;

  assign pc_write   = c.pc_write;
  assign adr_src    = c.adr_src;
  assign mem_write  = c.mem_write;
  assign ir_write   = c.ir_write;
  assign result_src = c.result_src;
  assign alu_src_a  = c.alu_src_a;
  assign alu_src_b  = c.alu_src_b;
  assign reg_write  = c.reg_write;
  assign instr_done = c.instr_done;
  assign illegal    = c.illegal;
  assign imm_src    = imm_sel(op);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: per-instruction expected traces derived from the
// instruction class and cycle index, checked every cycle, plus literal pins.
module tb_multicycle_controller;

  logic       clk = 1'b0, reset = 1'b1;
  logic [6:0] op = 7'b0110011;
  logic [2:0] funct3 = 3'b000;
  logic       funct7b5 = 1'b0, zero = 1'b0, lt = 1'b0, ltu = 1'b0;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, instr_done, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [3:0] alu_control;
  logic [2:0] imm_src;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .lt(lt), .ltu(ltu), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .imm_src(imm_src), .reg_write(reg_write), .instr_done(instr_done),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef enum {C_LOAD, C_STORE, C_R, C_I, C_BR, C_JAL, C_JALR, C_LUI, C_AUIPC, C_ILL} cls_t;

  typedef struct {
    int pc, adr, mw, ir, res, a, b, alu, imm, rw, done, ill;
    bit c_adr, c_res, c_a, c_b, c_alu;
  } exp_t;

  typedef struct {
    int pc, adr, mw, ir, res, a, b, alu, imm, rw, done, ill;
  } obs_t;

  int    npass = 0, ntotal = 0;
  bit    chk_en = 1'b0;
  exp_t  cur;
  string cur_tag = "none";
  obs_t  snap [16];

  task automatic chk(input string name, input int act, input int exp);
    ntotal++;
    if (act == exp) npass++;
    else $display("FAIL %s act=%0d exp=%0d", name, act, exp);
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.pc = pc_write; o.adr = adr_src; o.mw = mem_write; o.ir = ir_write;
    o.res = result_src; o.a = alu_src_a; o.b = alu_src_b; o.alu = alu_control;
    o.imm = imm_src; o.rw = reg_write; o.done = instr_done; o.ill = illegal;
    return o;
  endfunction

  function automatic cls_t classify(input logic [6:0] o);
    case (o)
      7'b0000011: return C_LOAD;
      7'b0100011: return C_STORE;
      7'b0110011: return C_R;
      7'b0010011: return C_I;
      7'b1100011: return C_BR;
      7'b1101111: return C_JAL;
      7'b1100111: return C_JALR;
      7'b0110111: return C_LUI;
      7'b0010111: return C_AUIPC;
      default:    return C_ILL;
    endcase
  endfunction

  function automatic int ncyc(input cls_t c);
    case (c)
      C_LOAD, C_JALR: return 5;
      C_BR:           return 3;
      C_ILL:          return 12;
      default:        return 4;
    endcase
  endfunction

  function automatic int imm_of(input cls_t c);
    case (c)
      C_STORE:          return 1;
      C_BR:             return 2;
      C_JAL:            return 3;
      C_LUI, C_AUIPC:   return 4;
      default:          return 0;
    endcase
  endfunction

  // ALU code from the function table: ADD SLL SLT SLTU XOR SRL OR AND.
  function automatic int alu_of(input bit rtype, input logic [2:0] f3, input logic f7);
    int tab [8];
    tab = '{0, 7, 5, 6, 4, 8, 3, 2};
    if (f3 == 3'd0 && rtype && f7) return 1;
    if (f3 == 3'd5 && f7) return 9;
    return tab[f3];
  endfunction

  function automatic bit taken_of(input logic [2:0] f3, input logic z, l, lu);
    case (f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return l;
      3'd5: return !l;
      3'd6: return lu;
      default: return !lu;
    endcase
  endfunction

  function automatic exp_t blank(input cls_t c);
    exp_t e;
    e = '{default: 0};
    e.imm = imm_of(c);
    return e;
  endfunction

  function automatic exp_t path(input exp_t ei, input int a, b, alu);
    exp_t e = ei;
    e.c_a = 1; e.a = a; e.c_b = 1; e.b = b; e.c_alu = 1; e.alu = alu;
    return e;
  endfunction

  function automatic exp_t wb(input exp_t ei);
    exp_t e = ei;
    e.c_res = 1; e.res = 0; e.rw = 1; e.done = 1;
    return e;
  endfunction

  // Expected outputs for cycle k of an instruction of class c.
  function automatic exp_t model(input cls_t c, input int k, input logic [2:0] f3,
                                 input logic f7, z, l, lu);
    exp_t e = blank(c);
    if (k == 0) begin
      e = path(e, 0, 2, 0);
      e.ir = 1; e.pc = 1; e.c_adr = 1; e.adr = 0; e.c_res = 1; e.res = 2;
      return e;
    end
    if (k == 1) return path(e, 1, 1, 0);
    case (c)
      C_R:     e = (k == 2) ? path(e, 2, 0, alu_of(1, f3, f7)) : wb(e);
      C_I:     e = (k == 2) ? path(e, 2, 1, alu_of(0, f3, f7)) : wb(e);
      C_LUI:   e = (k == 2) ? path(e, 3, 1, 0) : wb(e);
      C_AUIPC: e = (k == 2) ? path(e, 1, 1, 0) : wb(e);
      C_LOAD: begin
        if (k == 2) e = path(e, 2, 1, 0);
        else if (k == 3) begin e.c_adr = 1; e.adr = 1; e.c_res = 1; e.res = 0; end
        else begin e.c_res = 1; e.res = 1; e.rw = 1; e.done = 1; end
      end
      C_STORE: begin
        if (k == 2) e = path(e, 2, 1, 0);
        else begin e.c_adr = 1; e.adr = 1; e.c_res = 1; e.res = 0; e.mw = 1; e.done = 1; end
      end
      C_BR: begin
        e = path(e, 2, 0, 1);
        e.c_res = 1; e.res = 0; e.done = 1; e.pc = taken_of(f3, z, l, lu);
      end
      C_JAL: begin
        if (k == 2) begin e = path(e, 1, 2, 0); e.c_res = 1; e.res = 0; e.pc = 1; end
        else e = wb(e);
      end
      C_JALR: begin
        if (k == 2) e = path(e, 2, 1, 0);
        else if (k == 3) begin e = path(e, 1, 2, 0); e.c_res = 1; e.res = 0; e.pc = 1; end
        else e = wb(e);
      end
      default: e.ill = 1;
    endcase
    return e;
  endfunction

  // Every cycle the bench has an expectation: compare all cared-for outputs.
  always @(negedge clk) begin
    if (chk_en) begin
      obs_t o;
      o = sample();
      chk({cur_tag, ".pc_write"},   o.pc,   cur.pc);
      chk({cur_tag, ".mem_write"},  o.mw,   cur.mw);
      chk({cur_tag, ".ir_write"},   o.ir,   cur.ir);
      chk({cur_tag, ".reg_write"},  o.rw,   cur.rw);
      chk({cur_tag, ".instr_done"}, o.done, cur.done);
      chk({cur_tag, ".illegal"},    o.ill,  cur.ill);
      chk({cur_tag, ".imm_src"},    o.imm,  cur.imm);
      if (cur.c_adr) chk({cur_tag, ".adr_src"},     o.adr, cur.adr);
      if (cur.c_res) chk({cur_tag, ".result_src"},  o.res, cur.res);
      if (cur.c_a)   chk({cur_tag, ".alu_src_a"},   o.a,   cur.a);
      if (cur.c_b)   chk({cur_tag, ".alu_src_b"},   o.b,   cur.b);
      if (cur.c_alu) chk({cur_tag, ".alu_control"}, o.alu, cur.alu);
    end
  end

  // Hold reset for n cycles; outputs must show no enables and no illegal.
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      reset = 1'b1;
      cur = blank(classify(op));
      cur_tag = $sformatf("reset%0d", i);
      chk_en = 1'b1;
      #3 snap[i] = sample();
    end
  endtask

  // Run one instruction from its FETCH cycle; rst_at>=0 asserts reset in that cycle
  // and ends the instruction there.
  task automatic run(input string nm, input logic [6:0] o, input logic [2:0] f3,
                     input logic f7, z, l, lu, input int rst_at);
    cls_t c = classify(o);
    int   n = (rst_at >= 0) ? rst_at + 1 : ncyc(c);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        reset = 1'b0; op = o; funct3 = f3; funct7b5 = f7; zero = z; lt = l; ltu = lu;
      end
      if (k == rst_at) begin
        reset = 1'b1;
        cur = blank(c);
      end else begin
        cur = model(c, k, f3, f7, z, l, lu);
      end
      cur_tag = $sformatf("%s.c%0d", nm, k);
      chk_en = 1'b1;
      #3 snap[k] = sample();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(3);
    chk("rst.ir_write", snap[2].ir, 0);
    chk("rst.pc_write", snap[2].pc, 0);

    run("add", 7'b0110011, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    chk("post_rst.ir_write", snap[0].ir, 1);
    chk("post_rst.pc_write", snap[0].pc, 1);
    chk("post_rst.adr_src", snap[0].adr, 0);
    chk("add.alu", snap[2].alu, 0);
    chk("add.rw_c3", snap[2].rw, 0);
    chk("add.rw_c4", snap[3].rw, 1);
    chk("add.done_c4", snap[3].done, 1);

    run("sub",  7'b0110011, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    chk("sub.alu", snap[2].alu, 1);
    run("sra",  7'b0110011, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    chk("sra.alu", snap[2].alu, 9);
    run("sltu", 7'b0110011, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    run("addi_f7", 7'b0010011, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    chk("addi.alu", snap[2].alu, 0);
    run("srai", 7'b0010011, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    run("ori",  7'b0010011, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, -1);

    run("lw", 7'b0000011, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    chk("lw.imm", snap[1].imm, 0);
    chk("lw.adr_c4", snap[3].adr, 1);
    chk("lw.res_c5", snap[4].res, 1);
    chk("lw.rw_c5", snap[4].rw, 1);
    run("sw", 7'b0100011, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    chk("sw.mw_c4", snap[3].mw, 1);

    run("beq_t",  7'b1100011, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    chk("beq_t.pc_c3", snap[2].pc, 1);
    chk("beq_t.imm", snap[2].imm, 2);
    run("beq_nt", 7'b1100011, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    chk("beq_nt.pc_c3", snap[2].pc, 0);
    run("bgeu",   7'b1100011, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    chk("bgeu.pc_c3", snap[2].pc, 1);
    run("blt",    7'b1100011, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    run("bne_nt", 7'b1100011, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1, -1);
    run("bltu_nt", 7'b1100011, 3'd6, 1'b0, 1'b0, 1'b1, 1'b0, -1);

    run("jal", 7'b1101111, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    chk("jal.imm", snap[0].imm, 3);
    chk("jal.pc_c3", snap[2].pc, 1);
    chk("jal.rw_c4", snap[3].rw, 1);
    run("jalr", 7'b1100111, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    chk("jalr.pc_c4", snap[3].pc, 1);
    run("lui", 7'b0110111, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    chk("lui.imm", snap[2].imm, 4);
    chk("lui.src_a", snap[2].a, 3);
    run("auipc", 7'b0010111, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, -1);

    // Reset in MEM_READ of a load, then in MEM_WB of another: no writes,
    // and the following instruction starts in FETCH.
    run("lw_rst_rd", 7'b0000011, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    run("add2", 7'b0110011, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    run("lw_rst_wb", 7'b0000011, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4);
    chk("lw_rst_wb.rw", snap[4].rw, 0);
    run("xor", 7'b0110011, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, -1);

    run("ill", 7'b1111111, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    chk("ill.sticky_c12", snap[11].ill, 1);
    chk("ill.pc_c12", snap[11].pc, 0);
    do_reset(2);
    chk("ill_rst.illegal", snap[1].ill, 0);
    run("and", 7'b0110011, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, -1);

    @(posedge clk); #1 chk_en = 1'b0;
    @(posedge clk);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Control FSM for the multicycle RV32I core. It sits directly upstream of the immediate extender, driving its 3-bit imm_src, and of the ALU, register file, PC and instruction register, sequencing each instruction through fetch, decode, execute, memory and writeback. It consumes the latched instruction fields and the ALU flags. It produces all datapath enables and mux selects.

Parameters:
None. All encodings are fixed package constants.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
op  in  7  instr[6:0] from instruction register
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
zero  in  1  ALU result == 0
lt  in  1  signed rs1 < rs2
ltu  in  1  unsigned rs1 < rs2
pc_write  out  1  PC register load enable
adr_src  out  1  memory address select: 0=PC, 1=result
mem_write  out  1  data memory write enable
ir_write  out  1  instruction register and old_pc load enable
result_src  out  2  result mux select: 00=alu_out reg, 01=mem data, 10=alu result
alu_src_a  out  2  ALU A select: 00=PC, 01=old_pc, 10=rs1 reg, 11=zero
alu_src_b  out  2  ALU B select: 00=rs2 reg, 01=imm_ext, 10=constant 4
alu_control  out  4  ALU operation code
imm_src  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U
reg_write  out  1  register file write enable
instr_done  out  1  one-cycle pulse in the final state of each instruction
illegal  out  1  sticky illegal-instruction flag

Behaviour:
- Clocking and outputs: one state register, updated on rising clk. Outputs are combinational from state (Moore), except pc_write in BRANCH, which also depends on flags.
- Reset: while reset=1, all enables (pc_write, mem_write, ir_write, reg_write, instr_done) are 0, illegal=0, and the next state is FETCH. Reset mid-instruction aborts it with no partial writes in the reset cycle. The first cycle after release is FETCH.
- Memory read data is valid in the same cycle as its address.
- imm_src is decoded from op alone, in every state:
  - load, OP-IMM, JALR → I
  - store → S
  - branch → B
  - JAL → J
  - LUI, AUIPC → U
  - R-type and illegal → 000
- ALU codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001.
- ALU decode, R-type, by funct3:
  - 000: SUB if funct7b5 else ADD
  - 001: SLL; 010: SLT; 011: SLTU; 100: XOR
  - 101: SRA if funct7b5 else SRL
  - 110: OR; 111: AND
- ALU decode, I-type: same table, except funct3=000 is always ADD.
- States and per-state actions:
  - FETCH: adr_src=0, ir_write=1, src_a=00, src_b=10, ADD, result_src=10, pc_write=1. Next: DECODE.
  - DECODE: src_a=01, src_b=01, ADD (branch/JAL target into alu_out). Next by op: load/store→MEM_ADR, R→EXEC_R, OP-IMM→EXEC_I, branch→BRANCH, JAL→JAL, JALR→JALR_ADR, LUI/AUIPC→EXEC_U, other→ILLEGAL.
  - MEM_ADR: src_a=10, src_b=01, ADD. Next: MEM_READ for load, MEM_WRITE for store.
  - MEM_READ: adr_src=1, result_src=00. Next: MEM_WB.
  - MEM_WB: result_src=01, reg_write=1, instr_done. Next: FETCH.
  - MEM_WRITE: adr_src=1, result_src=00, mem_write=1, instr_done. Next: FETCH.
  - EXEC_R: src_a=10, src_b=00, R decode. Next: ALU_WB.
  - EXEC_I: src_a=10, src_b=01, I decode. Next: ALU_WB.
  - EXEC_U: src_a=11 for LUI or 01 for AUIPC, src_b=01, ADD. Next: ALU_WB.
  - ALU_WB: result_src=00, reg_write=1, instr_done. Next: FETCH.
  - BRANCH: src_a=10, src_b=00, SUB, result_src=00, instr_done. pc_write = taken. Next: FETCH.
    - Taken by funct3: 000 zero; 001 !zero; 100 lt; 101 !lt; 110 ltu; 111 !ltu.
    - funct3 010 or 011: next ILLEGAL, no pc_write.
  - JAL: src_a=01, src_b=10, ADD, result_src=00, pc_write=1. Next: ALU_WB (writes old_pc+4).
  - JALR_ADR: src_a=10, src_b=01, ADD. Next: JALR.
  - JALR: src_a=01, src_b=10, ADD, result_src=00, pc_write=1. Next: ALU_WB. The datapath clears target bit 0.
  - ILLEGAL: all enables 0, illegal=1. Stays until reset.
- Cycle counts: R/I/U/JAL/store 4; load/JALR 5; branch 3.
- instr_done is never asserted in FETCH or DECODE.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state enum
  - opcode constants (0000011, 0100011, 0110011, 0010011, 1100011, 1101111, 1100111, 0110111, 0010111)
  - alu_control codes, imm_src codes, and mux select codes, all shared with the datapath and the immediate extender
- One sub-module, alu_decoder: combinational funct3/funct7b5 → alu_control, with a select for R, I or ADD-forced mode.

Test Plan:
- Reset held for 3 cycles, op=0110011 → all enables 0. First post-reset cycle: ir_write=1, pc_write=1, adr_src=0.
- add (op=0110011, funct3=000, funct7b5=0) → states FETCH, DECODE, EXEC_R, ALU_WB. alu_control=0000 in EXEC_R. reg_write=1 and instr_done=1 only in cycle 4.
- lw (op=0000011) → 5 cycles, imm_src=000, adr_src=1 in MEM_READ, result_src=01 with reg_write=1 in cycle 5.
- beq (funct3=000):
  - zero=1 → pc_write=1 in cycle 3, imm_src=010.
  - zero=0 → pc_write=0, back to FETCH.
  - bgeu (funct3=111), ltu=0 → taken.
- jal (op=1101111) → imm_src=011, pc_write in cycle 3 (JAL), reg_write in cycle 4. lui (op=0110111) → imm_src=100, alu_src_a=11.
- op=1111111 → ILLEGAL after DECODE, illegal=1 sticky for 10 cycles, no enables. Reset asserted in MEM_READ of a lw → no reg_write, FETCH after release.
